noise_monitor: RTL and testbench

- Receive-side counterpart of the noise generator: samples the per-lane noise bit vector over a programmable window and counts the ones per lane.
- Reports each lane's count serially over a valid/ready channel, so the bench or an on-chip checker can confirm that the injected noise frequency matches the configured value.
- Sits on the noise bus, alongside the soft associative memory array that consumes the same bits.

---
 rtl/noise_pkg.sv | 27 ++
 rtl/noise_monitor_if.sv | 39 +++
 rtl/noise_lane_counter.sv | 34 +++
 rtl/noise_monitor.sv | 135 +++++++++++++
 tb/tb_noise_monitor.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/noise_pkg.sv
// ---------------------------------------------------------------------------
// noise_pkg
// Shared definitions for the noise generator / noise monitor pair.
//   state_e              : monitor FSM states (IDLE, MEASURE, REPORT)
//   DEFAULT_LANES        : default number of observed noise lanes
//   DEFAULT_WINDOW_LOG2  : default log2 of the measurement window
//   expected_count()     : frequency code (0..256 per 256) -> expected ones in
//                          a window of 2^window_log2 samples
// ---------------------------------------------------------------------------
package noise_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    REPORT  = 2'd2
  } state_e;

  localparam int DEFAULT_LANES       = 8;
  localparam int DEFAULT_WINDOW_LOG2 = 8;

  // Same probability mapping the generator uses: a frequency code f means
  // f/256 probability per sample, so the expected count is f*2^W/256.
  function automatic int expected_count(input int freq, input int window_log2);
    return (freq << window_log2) >> 8;
  endfunction

endpackage

// File: rtl/noise_monitor_if.sv
// ---------------------------------------------------------------------------
// noise_monitor_if
// Result channel of the noise monitor.
//   res_valid / res_ready : handshake. A transfer happens on a posedge where
//                           both are high. Once res_valid rises, it and all
//                           payload fields hold stable until that transfer.
//   res_lane              : lane index of the presented result
//   res_count             : number of ones seen on res_lane in the window
//   res_last              : high with the final lane's result
//   res_flag              : (NOISE_MONITOR_THRESH_EN only) count outside
//                           exp_count +/- tol
// Modports: master = monitor side, slave = consumer side.
// ---------------------------------------------------------------------------
interface noise_monitor_if #(
  parameter int LANES = 8,
  parameter int CNT_W = 9
);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic              res_valid;
  logic              res_ready;
  logic [LANE_W-1:0] res_lane;
  logic [CNT_W-1:0]  res_count;
  logic              res_last;
`ifdef NOISE_MONITOR_THRESH_EN
  logic              res_flag;

  modport master (output res_valid, res_lane, res_count, res_last, res_flag,
                  input  res_ready);
  modport slave  (input  res_valid, res_lane, res_count, res_last, res_flag,
                  output res_ready);
`else
  modport master (output res_valid, res_lane, res_count, res_last,
                  input  res_ready);
  modport slave  (input  res_valid, res_lane, res_count, res_last,
                  output res_ready);
`endif

endinterface

// File: rtl/noise_lane_counter.sv
// ---------------------------------------------------------------------------
// noise_lane_counter
// Per-lane ones counter. Clear has priority over increment. The width is
// chosen by the parent to hold the full window count, so it never wraps.
//   clk, rst  : clock, asynchronous active-high reset
//   clear_i   : synchronous clear
//   inc_i     : add one this cycle
//   count_o   : current count
// ---------------------------------------------------------------------------
module noise_lane_counter #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/noise_monitor.sv
// ---------------------------------------------------------------------------
// noise_monitor
// Counts ones per noise lane over a window of 2^WINDOW_LOG2 accepted samples,
// then reports each lane's count in order over a valid/ready channel.
// Optional macro: NOISE_MONITOR_THRESH_EN adds exp_count/tol inputs and a
// res_flag output that marks results with |res_count - exp_count| > tol.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : begin a measurement (only honoured in IDLE)
//   sample_en  : noise_in is counted on this cycle
//   noise_in   : one noise bit per lane
//   busy       : high in MEASURE and REPORT
//   state_o    : current FSM state (debug)
//   exp_count, tol : threshold compare inputs (macro only)
//   res        : result channel (noise_monitor_if.master)
// ---------------------------------------------------------------------------
module noise_monitor
  import noise_pkg::*;
#(
  parameter int LANES       = DEFAULT_LANES,
  parameter int WINDOW_LOG2 = DEFAULT_WINDOW_LOG2,
  parameter int CNT_W       = WINDOW_LOG2 + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sample_en,
  input  logic [LANES-1:0] noise_in,
  output logic             busy,
  output state_e           state_o,
`ifdef NOISE_MONITOR_THRESH_EN
  input  logic [CNT_W-1:0] exp_count,
  input  logic [CNT_W-1:0] tol,
`endif
  noise_monitor_if.master  res
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  state_e                 state_q;
  logic [WINDOW_LOG2-1:0] sample_cnt_q;
  logic [LANE_W-1:0]      ptr_q;
  logic                   valid_q;

  logic                   clear_all;
  logic                   inc_en;
  logic [CNT_W-1:0]       lane_cnt [LANES];

  assign clear_all = (state_q == IDLE) && start;
  assign inc_en    = (state_q == MEASURE) && sample_en;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    noise_lane_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .clear_i (clear_all),
      .inc_i   (inc_en && noise_in[i]),
      .count_o (lane_cnt[i])
    );
  end

  // The sample counter runs through all 2^WINDOW_LOG2 values; the sample
  // accepted while it is all-ones is the last one of the window, and the
  // counter wraps back to zero on that same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      ptr_q        <= '0;
      valid_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= MEASURE;
            sample_cnt_q <= '0;
          end
        end
        MEASURE: begin
          if (sample_en) begin
            sample_cnt_q <= sample_cnt_q + WINDOW_LOG2'(1);
            if (&sample_cnt_q) begin
              state_q <= REPORT;
              valid_q <= 1'b1;
              ptr_q   <= '0;
            end
          end
        end
        REPORT: begin
          if (res.res_ready) begin
            if (ptr_q == LAST_LANE) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              ptr_q   <= '0;
            end else begin
              ptr_q <= ptr_q + LANE_W'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          ptr_q   <= '0;
        end
      endcase
    end
  end

  // Payload is a mux of registers that only change on a transfer (pointer)
  // or outside REPORT (counters), so it holds stable while stalled.
  assign busy          = (state_q != IDLE);
  assign state_o       = state_q;
  assign res.res_valid = valid_q;
  assign res.res_lane  = ptr_q;
  assign res.res_count = lane_cnt[ptr_q];
  assign res.res_last  = valid_q && (ptr_q == LAST_LANE);

`ifdef NOISE_MONITOR_THRESH_EN
  // One extra bit keeps the subtraction from wrapping.
  logic [CNT_W:0] abs_diff;

  always_comb begin
    abs_diff = '0;
    if (res.res_count >= exp_count) begin
      abs_diff = {1'b0, res.res_count} - {1'b0, exp_count};
    end else begin
      abs_diff = {1'b0, exp_count} - {1'b0, res.res_count};
    end
  end

  assign res.res_flag = valid_q && (abs_diff > {1'b0, tol});
`endif

endmodule

// File: tb/tb_noise_monitor.sv
// ---------------------------------------------------------------------------
// tb_noise_monitor
// Directed bench for noise_monitor with LANES=8, WINDOW_LOG2=4. Expected lane
// results are computed from the driven noise bits, pushed into exp_q when a
// window completes and popped as the DUT transfers each result.
// ---------------------------------------------------------------------------
module tb_noise_monitor;
  import noise_pkg::*;

  localparam int LANES  = 8;
  localparam int WL2    = 4;
  localparam int CNT_W  = WL2 + 1;
  localparam int WIN    = 1 << WL2;
  localparam int EW     = 1 + 1 + 3 + CNT_W;   // {flag, last, lane, count}

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             start     = 1'b0;
  logic             sample_en = 1'b0;
  logic [LANES-1:0] noise_in  = '0;
  logic             busy;
  state_e           dut_state;
  logic [CNT_W-1:0] exp_count = CNT_W'(8);
  logic [CNT_W-1:0] tol       = CNT_W'(2);

  noise_monitor_if #(.LANES(LANES), .CNT_W(CNT_W)) res_if ();

  noise_monitor #(.LANES(LANES), .WINDOW_LOG2(WL2), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sample_en (sample_en),
    .noise_in  (noise_in),
    .busy      (busy),
    .state_o   (dut_state),
`ifdef NOISE_MONITOR_THRESH_EN
    .exp_count (exp_count),
    .tol       (tol),
`endif
    .res       (res_if.master)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int model_cnt [LANES];
  int n_acc;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic begin_window();
    for (int i = 0; i < LANES; i++) model_cnt[i] = 0;
    n_acc = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_state", 32'(dut_state), 32'(MEASURE));
  endtask

  task automatic drive(input logic en, input logic [LANES-1:0] nz);
    sample_en = en;
    noise_in  = nz;
    if (en) begin
      n_acc++;
      for (int i = 0; i < LANES; i++) model_cnt[i] += int'(nz[i]);
    end
    step();
    sample_en = 1'b0;
  endtask

  function automatic logic model_flag(input int cnt);
`ifdef NOISE_MONITOR_THRESH_EN
    int d;
    d = (cnt > int'(exp_count)) ? cnt - int'(exp_count) : int'(exp_count) - cnt;
    return d > int'(tol);
`else
    return 1'b0;
`endif
  endfunction

  // Called right after the final sample's edge: first result is due now.
  task automatic end_window();
    logic [EW-1:0] e;
    check("win_valid", 32'(res_if.res_valid), 32'd1);
    check("win_state", 32'(dut_state), 32'(REPORT));
    for (int i = 0; i < LANES; i++) begin
      e = {model_flag(model_cnt[i]), (i == LANES - 1), 3'(i), CNT_W'(model_cnt[i])};
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [EW-1:0] observed();
    logic f;
`ifdef NOISE_MONITOR_THRESH_EN
    f = res_if.res_flag;
`else
    f = 1'b0;
`endif
    return {f, res_if.res_last, res_if.res_lane, res_if.res_count};
  endfunction

  task automatic drain();
    int cycles = 0;
    logic [EW-1:0] e;
    res_if.res_ready = 1'b1;
    while (exp_q.size() > 0 && cycles < 200) begin
      if (res_if.res_valid) begin
        e = exp_q.pop_front();
        check("result", 32'(observed()), 32'(e));
      end
      step();
      cycles++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    res_if.res_ready = 1'b0;
    check("post_busy", 32'(busy), 32'd0);
    check("post_valid", 32'(res_if.res_valid), 32'd0);
    check("post_last", 32'(res_if.res_last), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LANES-1:0] nz;
    res_if.res_ready = 1'b0;

    // reset values
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(res_if.res_valid), 32'd0);
    check("rst_lane", 32'(res_if.res_lane), 32'd0);
    check("rst_count", 32'(res_if.res_count), 32'd0);
    check("rst_last", 32'(res_if.res_last), 32'd0);
    check("rst_state", 32'(dut_state), 32'(IDLE));
    rst = 1'b0;
    step();

    // all ones over the full window
    begin_window();
    for (int k = 0; k < WIN; k++) begin
      if (k == WIN - 1) check("ff_early_valid", 32'(res_if.res_valid), 32'd0);
      drive(1'b1, 8'hFF);
    end
    end_window();
    drain();

    // alternating 55/AA
    begin_window();
    for (int k = 0; k < WIN; k++) drive(1'b1, (k % 2 == 0) ? 8'h55 : 8'hAA);
    end_window();
    drain();

    // sample_en every other cycle; disabled cycles carry FF to prove gating
    begin_window();
    for (int k = 0; k < WIN; k++) begin
      drive(1'b0, 8'hFF);
      if (k == WIN - 1) check("half_early_valid", 32'(res_if.res_valid), 32'd0);
      drive(1'b1, 8'h01);
    end
    end_window();
    drain();

    // stall in REPORT with a stray start pulse
    begin_window();
    for (int k = 0; k < WIN; k++) drive(1'b1, 8'($urandom));
    end_window();
    for (int c = 0; c < 5; c++) begin
      check("stall_valid", 32'(res_if.res_valid), 32'd1);
      check("stall_lane", 32'(res_if.res_lane), 32'd0);
      check("stall_count", 32'(res_if.res_count), 32'(model_cnt[0]));
      start = (c == 2);
      step();
      start = 1'b0;
    end
    drain();
    step();
    check("no_restart_busy", 32'(busy), 32'd0);

    // reset mid-measurement, then an all-zero window
    begin_window();
    for (int k = 0; k < 10; k++) drive(1'b1, 8'hFF);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_state", 32'(dut_state), 32'(IDLE));
    #2 rst = 1'b0;
    step();
    begin_window();
    for (int k = 0; k < WIN; k++) drive(1'b1, 8'h00);
    end_window();
    drain();

    // random sample_en and noise
    begin_window();
    while (n_acc < WIN) drive(1'($urandom_range(0, 1)), 8'($urandom));
    end_window();
    drain();

    // lane 3 sees 11 ones, lane 4 sees 10 (flag boundary when enabled)
    begin_window();
    for (int k = 0; k < WIN; k++) begin
      nz = '0;
      nz[3] = (k < 11);
      nz[4] = (k < 10);
      drive(1'b1, nz);
    end
    end_window();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
